oq_header_parser: RTL and testbench
===================================

# oq_header_parser

Snoops the word stream written into the output-queue input FIFO, extracts the IOQ module header of each packet, and queues one descriptor per packet (destination output-queue index, byte length, word length) for the packet-store stage. It sits beside the input FIFO, directly upstream of the store stage, which pops descriptors with `rd_dst_oq`. A small first-word-fallthrough descriptor FIFO decouples header arrival from store-stage consumption.

## Interface

**Parameters**
- `DATA_WIDTH`, 64: data bus width.
- `CTRL_WIDTH`, `DATA_WIDTH/8`: ctrl bus width.
- `NUM_OUTPUT_QUEUES`, 5: number of output queues.
- `NUM_OQ_WIDTH`, `log2(NUM_OUTPUT_QUEUES)`: queue index width.
- `PKT_LEN_WIDTH`, 11: byte-length width.
- `PKT_WORDS_WIDTH`, `PKT_LEN_WIDTH-log2(CTRL_WIDTH)`: word-length width.
- `IOQ_HDR_CTRL`, 8'hFF: ctrl value marking the IOQ header word.
- `DESC_FIFO_DEPTH_BITS`, 2: descriptor FIFO depth is 2^N, so 4 entries by default.

**Ports**
- `clk`, in, 1: clock.
- `reset`, in, 1: reset; synchronous, active-high.
- `in_data`, in, `DATA_WIDTH`: word being written to the input FIFO.
- `in_ctrl`, in, `CTRL_WIDTH`: ctrl of that word.
- `in_wr`, in, 1: word valid this cycle.
- `dst_oq_avail`, out, 1: descriptor FIFO not empty.
- `parsed_dst_oq`, out, `NUM_OQ_WIDTH`: head descriptor queue index.
- `parsed_pkt_byte_len`, out, `PKT_LEN_WIDTH`: head descriptor byte length.
- `parsed_pkt_word_len`, out, `PKT_WORDS_WIDTH`: head descriptor word length.
- `rd_dst_oq`, in, 1: pop the head descriptor.
- `desc_nearly_full`, out, 1: at most 1 free descriptor entry; used by the upstream flow control.
- `hdr_err`, out, 1: one-cycle pulse on a header error.
- `desc_overflow`, out, 1: one-cycle pulse when a push is lost because the FIFO is full.

## Operation

**IOQ header fields** (header word has `in_ctrl == IOQ_HDR_CTRL`)
- Destination one-hot: `[48+NUM_OUTPUT_QUEUES-1:48]`.
- Word length: `[47:32]`, truncated to `PKT_WORDS_WIDTH`.
- Byte length: `[15:0]`, truncated to `PKT_LEN_WIDTH`.

**Queue index**
- `parsed_dst_oq` is the index of the lowest set destination bit.
- All-zero destination: index = 0, `hdr_err` pulses, and the descriptor is still pushed. This keeps one descriptor per packet for the store stage.

**State machine** (one-hot): ST_WAIT_HDR, ST_HDRS, ST_PAYLOAD. All transitions are qualified by `in_wr`.
- ST_WAIT_HDR:
  - `in_ctrl == IOQ_HDR_CTRL`: push the descriptor, go to ST_HDRS.
  - `in_ctrl == 0`: packet without an IOQ header. Pulse `hdr_err`, push nothing, go to ST_PAYLOAD.
  - Other nonzero ctrl: ignored; stay in ST_WAIT_HDR.
- ST_HDRS (remaining module headers):
  - `in_ctrl == 0`: go to ST_PAYLOAD.
  - A second `IOQ_HDR_CTRL` word: pulse `hdr_err`, no push.
- ST_PAYLOAD:
  - End of packet = first word with `in_ctrl != 0` after a word with ctrl == 0.
  - On end of packet: go to ST_WAIT_HDR. The next header can arrive on the very next cycle.

**Descriptor FIFO**
- First-word fallthrough. Outputs always show the head entry.
- When empty, outputs hold their last value; 0 after reset.
- `rd_dst_oq` while empty: ignored; pointers unchanged.
- Push while full:
  - With no `rd_dst_oq` that cycle: entry discarded, `desc_overflow` pulses.
  - With `rd_dst_oq` that cycle: push and pop both succeed; occupancy unchanged.
- Simultaneous push and pop at any other occupancy: both succeed.
- Pointer wrap is modulo 2^`DESC_FIFO_DEPTH_BITS`. The count register is `DESC_FIFO_DEPTH_BITS+1` bits wide.
- `desc_nearly_full` = (count >= depth-1).

## Timing

- Header word written in cycle N: entry visible with `dst_oq_avail` = 1 in cycle N+1 (FIFO was empty).
- `rd_dst_oq` asserted in cycle N: the next entry, or `dst_oq_avail` = 0, is presented in cycle N+1.
- `hdr_err` and `desc_overflow` are registered: they pulse in the cycle after the offending word.
- Reset values:
  - State: ST_WAIT_HDR.
  - FIFO empty, `dst_oq_avail` = 0.
  - `parsed_*` = 0.
  - `desc_nearly_full`, `hdr_err`, `desc_overflow` = 0.
- Reset mid-packet:
  - All descriptors are discarded.
  - After reset the parser is in ST_WAIT_HDR, so payload words with ctrl == 0 that follow are flagged `hdr_err` and not pushed.
- No combinational path from `in_*` to any output.

## Test plan

- **Single packet.** Header `dst[52:48]` = 5'b00100, word len 9, byte len 64, followed by 8 data words (last ctrl = 8'h80).
  - Next cycle: `dst_oq_avail` = 1, `parsed_dst_oq` = 2, byte len = 64, word len = 9.
  - After `rd_dst_oq`: `dst_oq_avail` = 0.
- **Multi-bit destination.** One-hot = 5'b10010 -> `parsed_dst_oq` = 1.
- **Zero destination.** One-hot = 0 -> descriptor pushed with `parsed_dst_oq` = 0; `hdr_err` pulses exactly once.
- **Back-to-back packets.** 5 packets with no pops:
  - 4 descriptors stored; `desc_nearly_full` = 1 after the 3rd.
  - 5th header: `desc_overflow` pulses.
  - Pops then return packets 1-4 in order.
- **Full with simultaneous push and pop.** FIFO full; 5th header with `rd_dst_oq` in the same cycle: no overflow, count stays 4, order preserved.
- **Headerless packet, then reset.**
  - Data words with ctrl == 0 arriving in ST_WAIT_HDR: `hdr_err` pulses, no push.
  - Assert `reset` mid-payload with 2 entries queued: `dst_oq_avail` = 0 next cycle; a following well-formed packet parses normally.

Source files
------------

// File: rtl/oq_header_parser_if.sv
// Bus bundle for oq_header_parser: the input-FIFO write snoop and the
// descriptor pop/status side.
interface oq_header_parser_if #(
  parameter int DATA_WIDTH        = 64,
  parameter int CTRL_WIDTH        = DATA_WIDTH/8,
  parameter int NUM_OUTPUT_QUEUES = 5,
  parameter int NUM_OQ_WIDTH      = $clog2(NUM_OUTPUT_QUEUES),
  parameter int PKT_LEN_WIDTH     = 11,
  parameter int PKT_WORDS_WIDTH   = PKT_LEN_WIDTH - $clog2(CTRL_WIDTH)
);
  logic [DATA_WIDTH-1:0]      in_data;
  logic [CTRL_WIDTH-1:0]      in_ctrl;
  logic                       in_wr;
  logic                       dst_oq_avail;
  logic [NUM_OQ_WIDTH-1:0]    parsed_dst_oq;
  logic [PKT_LEN_WIDTH-1:0]   parsed_pkt_byte_len;
  logic [PKT_WORDS_WIDTH-1:0] parsed_pkt_word_len;
  logic                       rd_dst_oq;
  logic                       desc_nearly_full;
  logic                       hdr_err;
  logic                       desc_overflow;

  modport master (
    output in_data, in_ctrl, in_wr, rd_dst_oq,
    input  dst_oq_avail, parsed_dst_oq, parsed_pkt_byte_len, parsed_pkt_word_len,
           desc_nearly_full, hdr_err, desc_overflow
  );

  modport slave (
    input  in_data, in_ctrl, in_wr, rd_dst_oq,
    output dst_oq_avail, parsed_dst_oq, parsed_pkt_byte_len, parsed_pkt_word_len,
           desc_nearly_full, hdr_err, desc_overflow
  );
endinterface

// File: rtl/oq_header_parser.sv
// Snoops the output-queue input FIFO write stream, extracts the IOQ header of
// each packet and queues one {dst_oq, byte_len, word_len} descriptor per packet.
module oq_header_parser #(
  parameter int DATA_WIDTH           = 64,
  parameter int CTRL_WIDTH           = DATA_WIDTH/8,
  parameter int NUM_OUTPUT_QUEUES    = 5,
  parameter int NUM_OQ_WIDTH         = $clog2(NUM_OUTPUT_QUEUES),
  parameter int PKT_LEN_WIDTH        = 11,
  parameter int PKT_WORDS_WIDTH      = PKT_LEN_WIDTH - $clog2(CTRL_WIDTH),
  parameter logic [CTRL_WIDTH-1:0] IOQ_HDR_CTRL = 8'hFF,
  parameter int DESC_FIFO_DEPTH_BITS = 2
) (
  input logic               clk,
  input logic               reset,
  oq_header_parser_if.slave bus
);
  localparam int DEPTH = 1 << DESC_FIFO_DEPTH_BITS;
  localparam int CNT_W = DESC_FIFO_DEPTH_BITS + 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_NFULL = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

  typedef struct packed {
    logic [NUM_OQ_WIDTH-1:0]    dst_oq;
    logic [PKT_LEN_WIDTH-1:0]   byte_len;
    logic [PKT_WORDS_WIDTH-1:0] word_len;
  } desc_t;

  typedef enum logic [2:0] {
    ST_WAIT_HDR = 3'b001,
    ST_HDRS     = 3'b010,
    ST_PAYLOAD  = 3'b100
  } state_t;

  state_t                         r_state;
  logic                           r_hdr_err;
  logic                           w_is_hdr;
  logic                           w_is_data;
  logic                           w_push;
  logic [NUM_OUTPUT_QUEUES-1:0]   w_dst_onehot;
  desc_t                          w_desc;

  // Only the header fields are consumed; the rest of the word is snooped but unused.
  logic w_unused_data;
  assign w_unused_data = ^{1'b0, bus.in_data};

  assign w_is_hdr     = (bus.in_ctrl == IOQ_HDR_CTRL);
  assign w_is_data    = (bus.in_ctrl == '0);
  assign w_dst_onehot = bus.in_data[48 +: NUM_OUTPUT_QUEUES];
  assign w_push       = bus.in_wr && (r_state == ST_WAIT_HDR) && w_is_hdr;

  // Lowest set destination bit wins; an empty mask falls back to queue 0.
  always_comb begin
    w_desc.dst_oq = '0;
    for (int i = NUM_OUTPUT_QUEUES - 1; i >= 0; i--)
      if (w_dst_onehot[i]) w_desc.dst_oq = NUM_OQ_WIDTH'(i);
    w_desc.byte_len = bus.in_data[PKT_LEN_WIDTH-1:0];
    w_desc.word_len = bus.in_data[32 +: PKT_WORDS_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_WAIT_HDR;
      r_hdr_err <= 1'b0;
    end else begin
      r_hdr_err <= 1'b0;
      if (bus.in_wr) begin
        case (r_state)
          ST_WAIT_HDR: begin
            if (w_is_hdr) begin
              r_state   <= ST_HDRS;
              r_hdr_err <= ~|w_dst_onehot;
            end else if (w_is_data) begin
              r_state   <= ST_PAYLOAD;
              r_hdr_err <= 1'b1;
            end
          end
          ST_HDRS: begin
            if (w_is_data)     r_state   <= ST_PAYLOAD;
            else if (w_is_hdr) r_hdr_err <= 1'b1;
          end
          ST_PAYLOAD: begin
            if (!w_is_data) r_state <= ST_WAIT_HDR;
          end
          default: r_state <= ST_WAIT_HDR;
        endcase
      end
    end
  end

  desc_t                           r_mem [DEPTH];
  desc_t                           r_head;
  logic [DESC_FIFO_DEPTH_BITS-1:0] r_wr_ptr;
  logic [DESC_FIFO_DEPTH_BITS-1:0] r_rd_ptr;
  logic [DESC_FIFO_DEPTH_BITS-1:0] w_rd_nxt;
  logic [CNT_W-1:0]                r_count;
  logic                            r_overflow;
  logic                            w_full;
  logic                            w_pop;
  logic                            w_wr;

  assign w_full   = (r_count == C_DEPTH);
  assign w_pop    = bus.rd_dst_oq && (r_count != '0);
  assign w_wr     = w_push && (!w_full || w_pop);
  assign w_rd_nxt = r_rd_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_desc;
  end

  // Head is a register so it keeps the last popped entry while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_head     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_push && w_full && !w_pop;
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= w_rd_nxt;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_pop && (r_count > C_ONE))
        r_head <= r_mem[w_rd_nxt];
      else if (w_wr && ((r_count == '0) || w_pop))
        r_head <= w_desc;
    end
  end

  assign bus.dst_oq_avail        = (r_count != '0);
  assign bus.parsed_dst_oq       = r_head.dst_oq;
  assign bus.parsed_pkt_byte_len = r_head.byte_len;
  assign bus.parsed_pkt_word_len = r_head.word_len;
  assign bus.desc_nearly_full    = (r_count >= C_NFULL);
  assign bus.hdr_err             = r_hdr_err;
  assign bus.desc_overflow       = r_overflow;
endmodule

// File: tb/tb_oq_header_parser.sv
// Directed bench for oq_header_parser: header extraction, FIFO full/overflow
// corners, headerless packets and mid-packet reset.
module tb_oq_header_parser;
  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  oq_header_parser_if u_if ();

  oq_header_parser dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [63:0] hdr(input logic [4:0] dst, input logic [15:0] wlen,
                                      input logic [15:0] blen);
    return {11'd0, dst, wlen, 16'd0, blen};
  endfunction

  task automatic send(input logic [7:0] ctrl, input logic [63:0] data, input logic rd = 1'b0);
    u_if.in_ctrl   = ctrl;
    u_if.in_data   = data;
    u_if.in_wr     = 1'b1;
    u_if.rd_dst_oq = rd;
    @(posedge clk); #1;
    u_if.in_wr     = 1'b0;
    u_if.rd_dst_oq = 1'b0;
  endtask

  // n-1 data words with ctrl 0, then the end-of-packet word
  task automatic body(input int n);
    for (int i = 0; i < n - 1; i++) send(8'h00, 64'(i));
    send(8'h80, 64'hDEAD);
  endtask

  task automatic pop();
    u_if.rd_dst_oq = 1'b1;
    @(posedge clk); #1;
    u_if.rd_dst_oq = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    u_if.in_data   = '0;
    u_if.in_ctrl   = '0;
    u_if.in_wr     = 1'b0;
    u_if.rd_dst_oq = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_avail", u_if.dst_oq_avail, 0);
    chk("rst_dst",   u_if.parsed_dst_oq, 0);
    chk("rst_blen",  u_if.parsed_pkt_byte_len, 0);
    chk("rst_wlen",  u_if.parsed_pkt_word_len, 0);
    chk("rst_nf",    u_if.desc_nearly_full, 0);
    chk("rst_herr",  u_if.hdr_err, 0);
    chk("rst_ovf",   u_if.desc_overflow, 0);

    // single packet
    send(8'hFF, hdr(5'b00100, 16'd9, 16'd64));
    chk("p1_avail", u_if.dst_oq_avail, 1);
    chk("p1_dst",   u_if.parsed_dst_oq, 2);
    chk("p1_blen",  u_if.parsed_pkt_byte_len, 64);
    chk("p1_wlen",  u_if.parsed_pkt_word_len, 9);
    chk("p1_herr",  u_if.hdr_err, 0);
    body(8);
    pop();
    chk("p1_empty", u_if.dst_oq_avail, 0);
    chk("p1_hold",  u_if.parsed_dst_oq, 2);

    // multi-bit destination
    send(8'hFF, hdr(5'b10010, 16'd3, 16'd20));
    chk("mb_dst",  u_if.parsed_dst_oq, 1);
    chk("mb_blen", u_if.parsed_pkt_byte_len, 20);
    body(2);
    pop();
    chk("mb_empty", u_if.dst_oq_avail, 0);

    // zero destination
    send(8'hFF, hdr(5'b00000, 16'd2, 16'd10));
    chk("z_avail", u_if.dst_oq_avail, 1);
    chk("z_dst",   u_if.parsed_dst_oq, 0);
    chk("z_herr",  u_if.hdr_err, 1);
    send(8'h00, 64'h1);
    chk("z_herr_once", u_if.hdr_err, 0);
    send(8'h80, 64'h2);
    pop();
    chk("z_empty", u_if.dst_oq_avail, 0);

    // five back-to-back packets, no pops
    for (int i = 0; i < 5; i++) begin
      send(8'hFF, hdr(5'(1 << i), 16'(i + 2), 16'(8 * (i + 2))));
      chk($sformatf("b2b_nf%0d", i),  u_if.desc_nearly_full, (i >= 2) ? 1 : 0);
      chk($sformatf("b2b_ovf%0d", i), u_if.desc_overflow, (i == 4) ? 1 : 0);
      send(8'h00, 64'h0);
      chk($sformatf("b2b_ovf_clr%0d", i), u_if.desc_overflow, 0);
      send(8'h80, 64'h0);
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b2b_dst%0d", i),  u_if.parsed_dst_oq, i);
      chk($sformatf("b2b_wlen%0d", i), u_if.parsed_pkt_word_len, i + 2);
      pop();
    end
    chk("b2b_empty", u_if.dst_oq_avail, 0);

    // full FIFO, push and pop in the same cycle
    for (int i = 0; i < 4; i++) begin
      send(8'hFF, hdr(5'(1 << i), 16'(i + 1), 16'(i + 1)));
      body(2);
    end
    chk("fp_full_nf", u_if.desc_nearly_full, 1);
    send(8'hFF, hdr(5'b10000, 16'd5, 16'd5), 1'b1);
    chk("fp_ovf",   u_if.desc_overflow, 0);
    chk("fp_nf",    u_if.desc_nearly_full, 1);
    chk("fp_avail", u_if.dst_oq_avail, 1);
    body(2);
    for (int i = 1; i < 5; i++) begin
      chk($sformatf("fp_dst%0d", i),  u_if.parsed_dst_oq, i);
      chk($sformatf("fp_blen%0d", i), u_if.parsed_pkt_byte_len, i + 1);
      pop();
    end
    chk("fp_empty", u_if.dst_oq_avail, 0);

    // headerless packet
    send(8'h00, 64'h11);
    chk("hl_herr",  u_if.hdr_err, 1);
    chk("hl_avail", u_if.dst_oq_avail, 0);
    send(8'h00, 64'h12);
    chk("hl_herr_once", u_if.hdr_err, 0);
    send(8'h80, 64'h13);
    chk("hl_nopush", u_if.dst_oq_avail, 0);

    // two entries queued, then reset in the middle of a third packet's payload
    send(8'hFF, hdr(5'b00010, 16'd2, 16'd16));
    body(2);
    send(8'hFF, hdr(5'b00100, 16'd2, 16'd16));
    body(2);
    chk("rq_avail", u_if.dst_oq_avail, 1);
    chk("rq_dst",   u_if.parsed_dst_oq, 1);
    send(8'hFF, hdr(5'b00001, 16'd4, 16'd32));
    send(8'h00, 64'h21);
    reset          = 1'b1;
    u_if.in_ctrl   = 8'h00;
    u_if.in_wr     = 1'b1;
    @(posedge clk); #1;
    reset          = 1'b0;
    u_if.in_wr     = 1'b0;
    chk("mr_avail", u_if.dst_oq_avail, 0);
    chk("mr_dst",   u_if.parsed_dst_oq, 0);
    chk("mr_nf",    u_if.desc_nearly_full, 0);
    send(8'h00, 64'h22);
    chk("mr_herr",  u_if.hdr_err, 1);
    chk("mr_nopush", u_if.dst_oq_avail, 0);
    send(8'h80, 64'h23);
    send(8'hFF, hdr(5'b01000, 16'd5, 16'd33));
    chk("ar_avail", u_if.dst_oq_avail, 1);
    chk("ar_dst",   u_if.parsed_dst_oq, 3);
    chk("ar_blen",  u_if.parsed_pkt_byte_len, 33);
    chk("ar_wlen",  u_if.parsed_pkt_word_len, 5);
    chk("ar_herr",  u_if.hdr_err, 0);
    body(4);
    pop();
    chk("ar_empty", u_if.dst_oq_avail, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
